gty_rx_capture: RTL
===================

Name: gty_rx_capture

Overview:
- Capture buffer for the GTY receive datapath; the receive-side counterpart of the GPIO-driven TX debug stage.
- Sits directly downstream of the GTY RX user interface. It records a burst of 80-bit RX words after an armed trigger.
- The PS reads the burst back through the same 32-bit GPIO write-bus/readback-word scheme the TX debug path uses.

Parameters:
- DEPTH_LOG2, 6, log2 of buffer depth; DEPTH = 2^DEPTH_LOG2 80-bit entries; legal range 1..10.
- BASE_ADDR, 16, first GPIO register address owned by this block; uses BASE_ADDR..BASE_ADDR+4.

Ports:
- clk  in  1  single clock for all logic (GTY RX user clock domain).
- rst  in  1  reset; synchronous, active-high.
- gpio_in  in  32  GPIO write bus: [15:0] addr, [23:16] data, [24] w_clk; [31:25] ignored.
- gpio_out  out  32  registered readback word.
- rx_data_in  in  80  GTY RX user data.
- rx_data_valid  in  1  qualifies rx_data_in for the current cycle.

Behaviour:
- Write strobe: wr = gpio_in[24] & ~w_clk_q, where w_clk_q is gpio_in[24] registered. A write is accepted only if gpio_in[15:0] is in BASE_ADDR..+4. The addressed register updates at the same edge.
- Registers, all reset to 0:
  - +0 CTRL (pulse bits, not stored): bit0 ARM, bit2 ABORT.
  - +1 stores MODE: bit0 = 0 means immediate trigger, 1 means match trigger.
  - +2 MATCH[7:0].
  - +3 MATCH[15:8].
  - +4 RD_SEL: [7:6] slice, [5:0] index bits.
  - RD_INDEX is DEPTH_LOG2 bits, loaded from the data byte and truncated; for DEPTH_LOG2 > 6 the upper bits are 0.
- FSM states, encoded: IDLE=0, ARMED=1, CAPTURE=2, DONE=3. Reset state is IDLE, fill=0, wr_ptr=0.
- IDLE: stays until ARM, then goes to ARMED with fill=0 and wr_ptr=0.
- ARMED:
  - Trigger = rx_data_valid & (MODE==0 | rx_data_in[15:0]==MATCH).
  - On trigger: write the word to entry 0, set fill=1, wr_ptr=1.
  - Next state is CAPTURE, or DONE if DEPTH==1.
  - A non-matching or invalid word is not stored.
- CAPTURE:
  - Each rx_data_valid cycle writes entry wr_ptr, then wr_ptr and fill each increment by 1.
  - The cycle that writes entry DEPTH-1 moves to DONE, with fill=DEPTH.
  - Invalid cycles hold all state (gaps allowed).
- DONE: holds the buffer and fill until ARM or ABORT.
- ARM in any state: restart into ARMED with fill=0. The capture in progress is discarded, even if rx_data_valid is high in the same cycle.
- ABORT in any state: go to IDLE with fill kept. ARM and ABORT in the same write: ABORT wins.
- No wrap-around: the buffer never overwrites past DEPTH-1 within one capture.
- Readback: gpio_out registered, 1-cycle latency from the RD_SEL/state/fill change.
  - Slice 0: mem[idx][31:0].
  - Slice 1: mem[idx][63:32].
  - Slice 2: {16'h0, mem[idx][79:64]}.
  - For slices 0-2, if idx >= fill the output is 32'h0.
  - Slice 3 (status): [1:0] state, [15:2] 0, [26:16] fill (zero-extended), [31:27] 0.
- gpio_out resets to 0. Buffer RAM is not reset; it is never visible because of the idx >= fill masking.
- Reading an entry in the same cycle it is written returns the new data on the following cycle.
- Reset mid-capture: next cycle IDLE, fill=0, gpio_out=0. All config registers are 0, so RD_SEL selects slice 0, idx 0, which reads back 0.

Test Plan:
- Reset, then set RD_SEL slice 3 -> gpio_out=0 (IDLE, fill 0). Write CTRL=1 -> status state=1, fill=0.
- Immediate mode: arm, drive 64 valid words data=i (i=0..63) with rx_data_valid toggling every other cycle -> state DONE, fill=64, entry 5 slice 0 reads 5, slice 2 reads 0. The 65th word is not stored.
- Match mode with MATCH=16'hBEEF: send 10 words with data[15:0]=0x1234, then 0x..BEEF, then 3 more -> entry 0 has low16 0xBEEF, fill=4, state CAPTURE. idx 4 reads 0.
- ABORT during CAPTURE at fill=7 -> IDLE, fill stays 7. Later valid words are not stored. Write with ARM|ABORT=0x05 -> IDLE.
- Re-ARM in DONE with rx_data_valid high in the same cycle -> ARMED, fill=0, that word not stored. Trigger on the next valid word -> fill=1.
- Write w_clk held high for 5 cycles -> exactly one register update. Write address BASE_ADDR+5 -> no effect. rst asserted mid-capture -> IDLE, fill 0, gpio_out 0 next cycle.

Source files
------------

// File: rtl/gty_rx_capture.sv
// GTY RX capture buffer: records a burst of 80-bit RX words after an armed
// trigger and exposes it to the PS through the GPIO write-bus/readback-word scheme.
module gty_rx_capture #(
  parameter int DEPTH_LOG2 = 6,
  parameter int BASE_ADDR  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  input  logic [79:0] rx_data_in,
  input  logic        rx_data_valid
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int DATA_W = 80;
  localparam int FILL_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [FILL_W-1:0]     fill, fill_n;
  logic [DEPTH_LOG2-1:0] wr_ptr, wr_ptr_n;

  logic                  w_clk_q;
  logic                  mode;
  logic [15:0]           match;
  logic [7:0]            rd_sel;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;

  logic [15:0]           addr_off;
  logic                  wr;
  logic                  arm;
  logic                  abort;
  logic                  trigger;

  logic [15:0]           rd_idx_wide;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_hit;
  logic                  unused_bits;

  function automatic logic [31:0] read_word(
    input logic [1:0]        slice,
    input logic [DATA_W-1:0] entry,
    input logic              hit,
    input logic [1:0]        st,
    input logic [FILL_W-1:0] f
  );
    logic [31:0] w;
    w = '0;
    case (slice)
      2'd0:    w = hit ? entry[31:0] : 32'h0;
      2'd1:    w = hit ? entry[63:32] : 32'h0;
      2'd2:    w = hit ? {16'h0, entry[79:64]} : 32'h0;
      default: begin
        w[1:0]          = st;
        w[16 +: FILL_W] = f;
      end
    endcase
    return w;
  endfunction

  // Unsigned offset wraps to a large value for addresses below the window.
  assign addr_off = gpio_in[15:0] - 16'(BASE_ADDR);
  assign wr       = gpio_in[24] & ~w_clk_q & (addr_off <= 16'd4);
  assign arm      = wr & (addr_off == 16'd0) & gpio_in[16];
  assign abort    = wr & (addr_off == 16'd0) & gpio_in[18];
  assign trigger  = rx_data_valid & (~mode | (rx_data_in[15:0] == match));

  // ---- GPIO register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      w_clk_q <= 1'b0;
      mode    <= 1'b0;
      match   <= 16'h0;
      rd_sel  <= 8'h0;
    end else begin
      w_clk_q <= gpio_in[24];
      if (wr) begin
        case (addr_off)
          16'd1:   mode        <= gpio_in[16];
          16'd2:   match[7:0]  <= gpio_in[23:16];
          16'd3:   match[15:8] <= gpio_in[23:16];
          16'd4:   rd_sel      <= gpio_in[23:16];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_n   = state;
    fill_n    = fill;
    wr_ptr_n  = wr_ptr;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr;
    if (abort) begin
      state_n = IDLE;
    end else if (arm) begin
      state_n  = ARMED;
      fill_n   = '0;
      wr_ptr_n = '0;
    end else begin
      case (state)
        ARMED: begin
          if (trigger) begin
            mem_we    = 1'b1;
            mem_waddr = '0;
            fill_n    = FILL_W'(1);
            wr_ptr_n  = DEPTH_LOG2'(1);
            state_n   = (DEPTH == 1) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (rx_data_valid) begin
            mem_we   = 1'b1;
            fill_n   = fill + FILL_W'(1);
            wr_ptr_n = wr_ptr + DEPTH_LOG2'(1);
            if (wr_ptr == DEPTH_LOG2'(DEPTH - 1)) begin
              state_n = DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---- capture control stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      fill   <= '0;
      wr_ptr <= '0;
    end else begin
      state  <= state_n;
      fill   <= fill_n;
      wr_ptr <= wr_ptr_n;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= rx_data_in;
    end
  end

  assign rd_idx_wide = {10'd0, rd_sel[5:0]};
  assign rd_idx      = rd_idx_wide[DEPTH_LOG2-1:0];
  assign rd_hit      = ({1'b0, rd_idx} < fill);
  assign unused_bits = ^{gpio_in[31:25], rd_idx_wide[15:DEPTH_LOG2]};

  // ---- readback stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out <= 32'h0;
    end else begin
      gpio_out <= read_word(rd_sel[7:6], mem[rd_idx], rd_hit, state, fill);
    end
  end

endmodule
